// File: rtl/mem_pkg.sv
// mem_pkg: FSM state type, funct3 encodings and the load-extension helper
// shared by the memory arbiter. Rev 1.0
`default_nettype none

package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [2:0] OP_B  = 3'd0;
  localparam logic [2:0] OP_H  = 3'd1;
  localparam logic [2:0] OP_W  = 3'd2;
  localparam logic [2:0] OP_BU = 3'd4;
  localparam logic [2:0] OP_HU = 3'd5;

  // RAM returns the addressed item in the low lanes; the arbiter extends it.
  function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [31:0] d);
    case (op)
      OP_B:    return {{24{d[7]}}, d[7:0]};
      OP_H:    return {{16{d[15]}}, d[15:0]};
      OP_BU:   return {24'd0, d[7:0]};
      OP_HU:   return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_align_check.sv
// mem_align_check: flags data accesses that must be rejected without touching RAM.
// Rev 1.0
`default_nettype none

module mem_align_check
  import mem_pkg::*;
(
  input  logic [2:0] op,
  input  logic [1:0] addr_lo,
  input  logic       we,
  output logic       illegal
);

  always_comb begin
    illegal = 1'b0;
    case (op)
      OP_B, OP_BU: illegal = we && (op == OP_BU);
      OP_H, OP_HU: illegal = addr_lo[0] || (we && (op == OP_HU));
      OP_W:        illegal = (addr_lo != 2'b00);
      default:     illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between a fetch port and a load/store port
// onto a single strobed RAM. Rev 1.0
`default_nettype none

module mem_arbiter
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_op,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        ram_load_n,
  output logic        ram_store_n,
  output logic [2:0]  ram_op,
  output logic [31:0] ram_addr,
  inout  wire  [31:0] ram_data
);

  state_t      state;
  logic [3:0]  cnt;
  logic        sel_data;    // granted port: 1 = data, 0 = fetch
  logic        last_grant;  // 1 = data port was served last
  logic        we;
  logic [31:0] wdata;
  logic        illegal;
  logic        grant_data;

  mem_align_check u_align (
    .op      (d_op),
    .addr_lo (d_addr[1:0]),
    .we      (d_we),
    .illegal (illegal)
  );

  assign grant_data = d_req && (!if_req || !last_grant);
  assign ram_data   = (!ram_store_n) ? wdata : 'z;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      sel_data    <= 1'b0;
      last_grant  <= 1'b1;
      we          <= 1'b0;
      wdata       <= '0;
      ram_load_n  <= 1'b1;
      ram_store_n <= 1'b1;
      ram_op      <= '0;
      ram_addr    <= '0;
      if_ready    <= 1'b0;
      if_rdata    <= '0;
      d_ready     <= 1'b0;
      d_err       <= 1'b0;
      d_rdata     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (if_req || d_req) begin
            sel_data <= grant_data;
            if (grant_data && illegal) begin
              state   <= ST_RESP;
              d_ready <= 1'b1;
              d_err   <= 1'b1;
            end else begin
              state <= ST_ACCESS;
              cnt   <= 4'(WAIT_CYCLES - 1);
              if (grant_data) begin
                ram_addr    <= d_addr;
                ram_op      <= d_op;
                we          <= d_we;
                wdata       <= d_wdata;
                ram_load_n  <= d_we;
                ram_store_n <= !d_we;
              end else begin
                ram_addr    <= if_addr & ~32'h3;
                ram_op      <= OP_W;
                we          <= 1'b0;
                ram_load_n  <= 1'b0;
                ram_store_n <= 1'b1;
              end
            end
          end
        end
        ST_ACCESS: begin
          if (cnt == 4'd0) begin
            ram_load_n  <= 1'b1;
            ram_store_n <= 1'b1;
            state       <= ST_RESP;
            if (sel_data) begin
              d_ready <= 1'b1;
              if (!we) d_rdata <= load_extend(ram_op, ram_data);
            end else begin
              if_ready <= 1'b1;
              if_rdata <= ram_data;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if_ready   <= 1'b0;
          d_ready    <= 1'b0;
          d_err      <= 1'b0;
          last_grant <= sel_data;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiter instances (WAIT_CYCLES 1 and 3) against a byte-level
// RAM environment and a transaction-level reference model. Rev 1.0
`default_nettype none

module tb_mem_arbiter;

  logic        clk;
  logic [1:0]  rst, if_req, d_req, d_we, if_ready, d_ready, d_err, load_n, store_n;
  logic [2:0]  d_op [2];
  logic [2:0]  ram_op [2];
  logic [31:0] if_addr [2], d_addr [2], d_wdata [2];
  logic [31:0] if_rdata [2], d_rdata [2], ram_addr [2], drv [2];
  wire  [31:0] bus0, bus1;

  int n_checks = 0;
  int n_fail   = 0;
  int ld_cnt [2], st_cnt [2], both_low [2];
  logic [31:0] st_data [2];
  logic [31:0] last_d [2];
  logic [31:0] mon_bus;

  // key = {ref_copy, instance, byte address}: copy 0 is the RAM, copy 1 the model
  logic [7:0] mem [logic [33:0]];

  mem_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst[0]), .if_req(if_req[0]), .if_addr(if_addr[0]),
    .if_ready(if_ready[0]), .if_rdata(if_rdata[0]), .d_req(d_req[0]), .d_we(d_we[0]),
    .d_op(d_op[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]), .d_ready(d_ready[0]),
    .d_err(d_err[0]), .d_rdata(d_rdata[0]), .ram_load_n(load_n[0]), .ram_store_n(store_n[0]),
    .ram_op(ram_op[0]), .ram_addr(ram_addr[0]), .ram_data(bus0));

  mem_arbiter #(.WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .rst(rst[1]), .if_req(if_req[1]), .if_addr(if_addr[1]),
    .if_ready(if_ready[1]), .if_rdata(if_rdata[1]), .d_req(d_req[1]), .d_we(d_we[1]),
    .d_op(d_op[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]), .d_ready(d_ready[1]),
    .d_err(d_err[1]), .d_rdata(d_rdata[1]), .ram_load_n(load_n[1]), .ram_store_n(store_n[1]),
    .ram_op(ram_op[1]), .ram_addr(ram_addr[1]), .ram_data(bus1));

  assign bus0 = load_n[0] ? 32'hzzzzzzzz : drv[0];
  assign bus1 = load_n[1] ? 32'hzzzzzzzz : drv[1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wc(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [7:0] getb(input logic [1:0] sel, input logic [31:0] a);
    if (mem.exists({sel, a})) return mem[{sel, a}];
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // Four bytes starting at a, then extended as the access size dictates.
  function automatic logic [31:0] mem_read(input logic [1:0] sel, input logic [31:0] a,
                                           input logic [2:0] op);
    logic [31:0] w;
    w = {getb(sel, a + 3), getb(sel, a + 2), getb(sel, a + 1), getb(sel, a)};
    case (op)
      3'd0:    return {{24{w[7]}}, w[7:0]};
      3'd1:    return {{16{w[15]}}, w[15:0]};
      3'd4:    return {24'd0, w[7:0]};
      3'd5:    return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic mem_write(input logic [1:0] sel, input logic [31:0] a, input logic [2:0] op,
                           input logic [31:0] d);
    int n;
    n = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) mem[{sel, a + 32'(i)}] = d[8*i +: 8];
  endtask

  function automatic bit model_illegal(input logic [2:0] op, input logic [31:0] a, input bit st);
    if (st && op > 3'd2) return 1'b1;
    if (op == 3'd0 || op == 3'd4) return 1'b0;
    if (op == 3'd1 || op == 3'd5) return a[0];
    if (op == 3'd2) return a[1:0] != 2'b00;
    return 1'b1;
  endfunction

  // RAM environment: raw bytes out during load strobe, byte writes during store strobe.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      mon_bus = (k == 0) ? bus0 : bus1;
      if (!load_n[k]) ld_cnt[k]++;
      if (!store_n[k]) begin
        st_cnt[k]++;
        st_data[k] = mon_bus;
        mem_write({1'b0, k[0]}, ram_addr[k], ram_op[k], mon_bus);
      end
      if (!load_n[k] && !store_n[k]) both_low[k]++;
      drv[k] = mem_read({1'b0, k[0]}, ram_addr[k], 3'd2);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset(input int k);
    @(negedge clk);
    rst[k] = 1'b1; if_req[k] = 1'b0; d_req[k] = 1'b0;
    repeat (2) @(negedge clk);
    rst[k] = 1'b0;
    last_d[k] = 32'd0;
  endtask

  task automatic preload(input int k, input logic [31:0] a, input logic [31:0] w);
    mem_write({1'b0, k[0]}, a, 3'd2, w);
    mem_write({1'b1, k[0]}, a, 3'd2, w);
  endtask

  // lat counts edges from the sampling edge (1) to the edge after which ready is seen.
  task automatic run_txn(input int k, input bit is_d, input bit we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd, input bit drop_early,
                         output int lat, output bit err, output logic [31:0] rd, output bit wide);
    @(negedge clk);
    ld_cnt[k] = 0; st_cnt[k] = 0; both_low[k] = 0;
    if (is_d) begin
      d_req[k] = 1'b1; d_we[k] = we; d_op[k] = op; d_addr[k] = addr; d_wdata[k] = wd;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end
    lat = -1; err = 1'b0; rd = '0; wide = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (is_d ? d_ready[k] : if_ready[k]) begin
        lat = n; err = d_err[k]; rd = is_d ? d_rdata[k] : if_rdata[k];
        break;
      end
      if (drop_early) begin if_req[k] = 1'b0; d_req[k] = 1'b0; end
    end
    if_req[k] = 1'b0; d_req[k] = 1'b0;
    if (lat > 0) begin
      @(posedge clk); #1;
      wide = if_ready[k] | d_ready[k];
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({load_n[k], store_n[k], ram_addr[k], ram_op[k], if_ready[k], d_ready[k], d_err[k],
           if_rdata[k], d_rdata[k]} !== {2'b11, 32'd0, 3'd0, 3'b000, 64'd0}) begin
        n_fail++;
        $display("FAIL reset_state k=%0d got ld_n=%b st_n=%b addr=%h op=%0d rdy=%b%b err=%b ifr=%h dr=%h required strobes 1, rest 0",
                 k, load_n[k], store_n[k], ram_addr[k], ram_op[k], if_ready[k], d_ready[k],
                 d_err[k], if_rdata[k], d_rdata[k]);
      end
    end
  endtask

  task automatic test_basic_load();
    int lat; bit err, wide; logic [31:0] rd;
    do_reset(0);
    preload(0, 32'h100, 32'hDEADBEEF);
    run_txn(0, 1'b1, 1'b0, 3'd2, 32'h100, 32'd0, 1'b0, lat, err, rd, wide);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL lw_latency got=%0d required=2", lat); end
    n_checks++;
    if (rd !== 32'hDEADBEEF || err !== 1'b0) begin
      n_fail++; $display("FAIL lw_data got=%h err=%b required=deadbeef err=0", rd, err);
    end
    n_checks++;
    if (ld_cnt[0] !== 1 || st_cnt[0] !== 0 || wide !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_strobes got load=%0d store=%0d wide=%b required 1 0 0", ld_cnt[0], st_cnt[0], wide);
    end
  endtask

  task automatic test_round_robin();
    int order [$];
    logic [31:0] got_if, got_d;
    do_reset(0);
    preload(0, 32'h300, 32'h11223344);
    preload(0, 32'h340, 32'h55667788);
    @(negedge clk);
    if_req[0] = 1'b1; if_addr[0] = 32'h302;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_op[0] = 3'd2; d_addr[0] = 32'h340;
    got_if = '0; got_d = '0;
    for (int n = 0; n < 60 && order.size() < 4; n++) begin
      @(posedge clk); #1;
      if (if_ready[0]) begin order.push_back(0); got_if = if_rdata[0]; end
      if (d_ready[0]) begin order.push_back(1); got_d = d_rdata[0]; end
    end
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (order.size() !== 4) begin
      n_fail++; $display("FAIL rr_count got=%0d completions required=4", order.size());
    end
    for (int i = 0; i < order.size() && i < 4; i++) begin
      n_checks++;
      if (order[i] !== i % 2) begin
        n_fail++; $display("FAIL rr_order slot=%0d got_port=%0d required_port=%0d (0=fetch)", i, order[i], i % 2);
      end
    end
    n_checks++;
    if (got_if !== 32'h11223344 || got_d !== 32'h55667788) begin
      n_fail++; $display("FAIL rr_data got if=%h d=%h required 11223344 55667788", got_if, got_d);
    end
    last_d[0] = 32'h55667788;
  endtask

  task automatic test_illegal();
    int lat; bit err, wide; logic [31:0] rd;
    logic [2:0] op; logic [31:0] a; bit we;
    do_reset(0);
    for (int i = 0; i < 7; i++) begin
      we = 1'b0;
      case (i)
        0: begin op = 3'd1; a = 32'h103; end
        1: begin op = 3'd3; a = 32'h100; end
        2: begin op = 3'd6; a = 32'h104; end
        3: begin op = 3'd7; a = 32'h108; we = 1'b1; end
        4: begin op = 3'd2; a = 32'h10A; end
        5: begin op = 3'd4; a = 32'h110; we = 1'b1; end
        default: begin op = 3'd5; a = 32'h111 + 32'($urandom_range(0, 7)) * 2; end
      endcase
      run_txn(0, 1'b1, we, op, a, $urandom, 1'b0, lat, err, rd, wide);
      n_checks++;
      if (lat !== 1 || err !== 1'b1 || ld_cnt[0] + st_cnt[0] !== 0) begin
        n_fail++;
        $display("FAIL illegal op=%0d addr=%h got lat=%0d err=%b strobes=%0d required lat=1 err=1 strobes=0",
                 op, a, lat, err, ld_cnt[0] + st_cnt[0]);
      end
    end
  endtask

  task automatic test_store_wait3();
    int lat; bit err, wide; logic [31:0] rd;
    do_reset(1);
    run_txn(1, 1'b1, 1'b1, 3'd0, 32'h201, 32'h000000A5, 1'b0, lat, err, rd, wide);
    n_checks++;
    if (st_cnt[1] !== 3 || ld_cnt[1] !== 0 || st_data[1] !== 32'h000000A5) begin
      n_fail++;
      $display("FAIL sb_strobe got store=%0d load=%0d data=%h required 3 0 000000a5", st_cnt[1], ld_cnt[1], st_data[1]);
    end
    n_checks++;
    if (lat !== 4 || err !== 1'b0 || rd !== 32'd0) begin
      n_fail++; $display("FAIL sb_resp got lat=%0d err=%b rdata=%h required 4 0 00000000", lat, err, rd);
    end
    run_txn(1, 1'b1, 1'b0, 3'd4, 32'h201, 32'd0, 1'b0, lat, err, rd, wide);
    n_checks++;
    if (lat !== 4 || rd !== 32'h000000A5) begin
      n_fail++; $display("FAIL lbu_readback got lat=%0d data=%h required 4 000000a5", lat, rd);
    end
    mem_write(2'b11, 32'h201, 3'd0, 32'hA5);
    last_d[1] = 32'h000000A5;
  endtask

  task automatic test_reset_mid_access();
    int pulses; int lat; bit err, wide; logic [31:0] rd;
    do_reset(1);
    preload(1, 32'h180, 32'hCAFEF00D);
    @(negedge clk);
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_op[1] = 3'd2; d_addr[1] = 32'h180;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (load_n[1] !== 1'b0) begin n_fail++; $display("FAIL abort_pre got ld_n=%b required 0", load_n[1]); end
    rst[1] = 1'b1; d_req[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    n_checks++;
    if (load_n[1] !== 1'b1 || store_n[1] !== 1'b1) begin
      n_fail++; $display("FAIL abort_strobes got ld_n=%b st_n=%b required 1 1", load_n[1], store_n[1]);
    end
    pulses = 0;
    repeat (8) begin @(posedge clk); #1; if (d_ready[1] || if_ready[1]) pulses++; end
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL abort_ready got=%0d pulses required=0", pulses); end
    run_txn(1, 1'b1, 1'b0, 3'd2, 32'h180, 32'd0, 1'b0, lat, err, rd, wide);
    n_checks++;
    if (lat !== 4 || rd !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL abort_recover got lat=%0d data=%h required 4 cafef00d", lat, rd);
    end
    last_d[1] = 32'hCAFEF00D;
  endtask

  task automatic test_random();
    int lat; bit err, wide; logic [31:0] rd;
    bit is_d, we, drop, bad, st; logic [2:0] op; logic [31:0] a, wd, ex_rd;
    int ex_lat;
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 24; t++) begin
        is_d = ($urandom_range(0, 2) != 0);
        we   = $urandom_range(0, 1) == 1;
        op   = 3'($urandom_range(0, 7));
        a    = 32'h400 + 32'($urandom_range(0, 31));
        wd   = $urandom;
        drop = ($urandom_range(0, 3) == 0);
        st   = is_d && we;
        bad  = is_d && model_illegal(op, a, st);
        ex_lat = bad ? 1 : wc(k) + 1;
        ex_rd  = last_d[k];
        if (!is_d) ex_rd = mem_read({1'b1, k[0]}, a & ~32'h3, 3'd2);
        else if (!bad && !we) ex_rd = mem_read({1'b1, k[0]}, a, op);
        if (!bad && st) mem_write({1'b1, k[0]}, a, op, wd);
        run_txn(k, is_d, we, op, a, wd, drop, lat, err, rd, wide);
        n_checks++;
        if (lat !== ex_lat || err !== bad || wide !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_timing k=%0d t=%0d d=%b we=%b op=%0d a=%h got lat=%0d err=%b wide=%b required %0d %b 0",
                   k, t, is_d, we, op, a, lat, err, wide, ex_lat, bad);
        end
        if (!bad) begin
          n_checks++;
          if (rd !== ex_rd) begin
            n_fail++;
            $display("FAIL rnd_rdata k=%0d t=%0d d=%b we=%b op=%0d a=%h got=%h required=%h", k, t, is_d, we, op, a, rd, ex_rd);
          end
          n_checks++;
          if (ld_cnt[k] !== ((st) ? 0 : wc(k)) || st_cnt[k] !== ((st) ? wc(k) : 0) || both_low[k] !== 0 ||
              (st && st_data[k] !== wd)) begin
            n_fail++;
            $display("FAIL rnd_strobes k=%0d t=%0d got load=%0d store=%0d both=%0d sdata=%h required store=%b wdata=%h",
                     k, t, ld_cnt[k], st_cnt[k], both_low[k], st_data[k], st, wd);
          end
          if (is_d && !we) last_d[k] = ex_rd;
        end
      end
    end
  endtask

  initial begin
    rst = 2'b11; if_req = '0; d_req = '0; d_we = '0;
    for (int k = 0; k < 2; k++) begin
      d_op[k] = '0; if_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0; drv[k] = '0;
      ld_cnt[k] = 0; st_cnt[k] = 0; both_low[k] = 0; st_data[k] = '0; last_d[k] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 2'b00;
    #1;
    test_reset();
    test_basic_load();
    test_round_robin();
    test_illegal();
    test_store_wait3();
    test_reset_mid_access();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, meaning number of cycles the RAM strobe is held active per access (legal 1..15).
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 if_req  in  1  fetch port request; held until if_ready.
REQ-005 if_addr  in  32  fetch word address; bits [1:0] ignored, forced 0 on RAM.
REQ-006 if_ready  out  1  one-cycle completion pulse for fetch.
REQ-007 if_rdata  out  32  fetched word, valid when if_ready=1, held until next fetch completion.
REQ-008 d_req  in  1  data port request; held until d_ready.
REQ-009 d_we  in  1  1 = store, 0 = load.
REQ-010 d_op  in  3  funct3: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
REQ-011 d_addr  in  32  byte address.  d_wdata  in  32  store data, LSB-aligned.
REQ-012 d_ready  out  1  one-cycle completion pulse.  d_err  out  1  qualifies d_ready: access rejected.
REQ-013 d_rdata  out  32  extended load result, valid with d_ready on non-error loads.
REQ-014 ram_load_n, ram_store_n  out  1 each  active-low RAM strobes.  ram_op  out  3.  ram_addr  out  32.  ram_data  inout  32.

Function
REQ-015 FSM states IDLE, ACCESS, RESP; reset state IDLE.
REQ-016 IDLE: if exactly one req is high, grant it; if both, grant the port not granted last (round-robin via last_grant bit); none -> stay IDLE.
REQ-017 Data grant with illegal access (d_op in {3,6,7}; halfword with addr[0]=1; word with addr[1:0]!=0; store with d_op in {4,5}) -> RESP directly, d_err=1, no RAM strobe.
REQ-018 Legal grant -> ACCESS; latch port, op, addr, wdata at grant edge; load counter with WAIT_CYCLES-1.
REQ-019 ACCESS: ram_addr, ram_op stable; ram_load_n=0 for loads/fetches, ram_store_n=0 for stores; never both 0.
REQ-020 ram_data driven with latched wdata only during store ACCESS; high-Z in every other cycle.
REQ-021 Counter decrements each ACCESS cycle; at zero, capture ram_data into rdata register (loads/fetches), go RESP.
REQ-022 RESP: pulse granted port's ready for exactly one cycle, update last_grant, return IDLE; strobes inactive.
REQ-023 Latency: req sampled in IDLE at cycle T -> ready at T+WAIT_CYCLES+1; illegal access -> ready at T+1.
REQ-024 Fetch always issues ram_op=2 (LW); other port's req ignored until IDLE.
REQ-025 Req deassertion mid-access does not abort; access completes and ready still pulses.
REQ-026 Store completion leaves d_rdata unchanged; d_err=0 on all legal completions.

Reset
REQ-027 On rst: state IDLE, ram_load_n=1, ram_store_n=1, ram_data high-Z, ram_addr=0, ram_op=0, if_ready=d_ready=d_err=0, if_rdata=d_rdata=0, last_grant=data (fetch wins first tie).
REQ-028 rst during ACCESS: strobes deassert at that edge, no ready pulse ever issued for the aborted access.

Structure
REQ-029 Shared package mem_pkg holds state enum and funct3 constants (OP_B, OP_H, OP_W, OP_BU, OP_HU).
REQ-030 Combinational sub-module mem_align_check (op, addr[1:0], we -> illegal) used by mem_arbiter.

Verification
REQ-031 Reset, then d_req load LW addr 0x100, RAM word 0xDEADBEEF -> ram_load_n low 1 cycle, d_ready at T+2, d_rdata=0xDEADBEEF.
REQ-032 if_req and d_req same cycle after reset -> fetch served first, then data; repeat both -> data first (alternation).
REQ-033 d_op=1 (LH) addr 0x103 -> d_ready+d_err at T+1, ram strobes never low.
REQ-034 SB 0xA5 addr 0x201, WAIT_CYCLES=3 -> ram_store_n low 3 cycles, ram_data=0x000000A5 during them, high-Z otherwise; LBU 0x201 then returns 0x000000A5.
REQ-035 rst asserted mid-ACCESS -> strobes high next edge, no ready pulse, next request served normally.
